// File: rtl/rgb565_frame_ctrl_pkg.sv
// Shared definitions for the RGB565->RGB888 frame path: FSM encoding and pixel field widths.
package video_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_RUN      = 2'd2,
      ST_DRAIN    = 2'd3
   } frame_state_e;

   localparam int R565_W   = 5;
   localparam int G565_W   = 6;
   localparam int B565_W   = 5;
   localparam int RGB565_W = R565_W + G565_W + B565_W;
   localparam int CH888_W  = 8;
   localparam int RGB888_W = 3 * CH888_W;

endpackage

// File: rtl/rgb565_frame_ctrl_if.sv
// Pixel stream bundle: RGB565 input stream (s_*) and RGB888 output stream (m_*).
interface rgb565_frame_ctrl_if;
   import video_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [RGB565_W-1:0] s_data;
   logic                s_sof;

   logic                m_valid;
   logic                m_ready;
   logic [RGB888_W-1:0] m_data;
   logic                m_sof;
   logic                m_eol;
   logic                m_eof;

   modport slave (
      input  s_valid, s_data, s_sof, m_ready,
      output s_ready, m_valid, m_data, m_sof, m_eol, m_eof
   );

   modport master (
      output s_valid, s_data, s_sof, m_ready,
      input  s_ready, m_valid, m_data, m_sof, m_eol, m_eof
   );

endinterface

// File: rtl/rgb565_frame_ctrl_conv.sv
// Combinational RGB565 -> RGB888 zero-fill expansion (low bits of each channel are 0).
module rgb565_to_rgb888
   import video_pkg::*;
(
   input  logic                rst_n,
   input  logic [RGB565_W-1:0] pix565,
   output logic [RGB888_W-1:0] pix888
);

   logic [R565_W-1:0] r;
   logic [G565_W-1:0] g;
   logic [B565_W-1:0] b;

   assign {r, g, b} = pix565;

   assign pix888 = rst_n ? {r, {(CH888_W-R565_W){1'b0}},
                            g, {(CH888_W-G565_W){1'b0}},
                            b, {(CH888_W-B565_W){1'b0}}}
                         : '0;

endmodule

// File: rtl/rgb565_frame_ctrl.sv
// Frame sequencer: arms per frame, locks to camera SOF, converts width*height pixels
// through one output register stage with SOF/EOL/EOF markers and done/err pulses.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | waiting for cfg_start; zero-size config pulses err
//   ST_WAIT_SOF | accepting and discarding beats until one carries s_sof
//   ST_RUN      | converting the frame; early SOF restarts it and pulses err
//   ST_DRAIN    | input stalled until the EOF beat leaves; then done
module rgb565_frame_ctrl
   import video_pkg::*;
#(
   parameter int DIM_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic [DIM_W-1:0] cfg_width,
   input  logic [DIM_W-1:0] cfg_height,
   output logic             busy,
   output logic             done,
   output logic             err,
   rgb565_frame_ctrl_if.slave bus
);

   frame_state_e        state_q, state_d;
   logic [DIM_W-1:0]    x_q, x_d, y_q, y_d;
   logic [DIM_W-1:0]    w_q, w_d, h_q, h_d;
   logic                mv_q, mv_d;
   logic [RGB888_W-1:0] md_q, md_d;
   logic                msof_q, msof_d, meol_q, meol_d, meof_q, meof_d;
   logic                done_q, done_d, err_q, err_d;

   logic                s_fire, m_fire, s_ready_int;
   logic [DIM_W-1:0]    px, py;
   logic                last_x, last_y;
   logic [RGB888_W-1:0] pix888;

   rgb565_to_rgb888 u_conv (
      .rst_n  (1'b1),
      .pix565 (bus.s_data),
      .pix888 (pix888)
   );

   assign s_ready_int = ((state_q == ST_WAIT_SOF) || (state_q == ST_RUN)) && (!mv_q || bus.m_ready);
   assign s_fire      = bus.s_valid && s_ready_int;
   assign m_fire      = mv_q && bus.m_ready;

   // An SOF beat is always pixel (0,0), whichever state accepts it.
   assign px     = bus.s_sof ? '0 : x_q;
   assign py     = bus.s_sof ? '0 : y_q;
   assign last_x = (px == w_q - DIM_W'(1));
   assign last_y = (py == h_q - DIM_W'(1));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      w_d     = w_q;
      h_d     = h_q;
      mv_d    = mv_q;
      md_d    = md_q;
      msof_d  = msof_q;
      meol_d  = meol_q;
      meof_d  = meof_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      if (m_fire) mv_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               if ((cfg_width == '0) || (cfg_height == '0)) begin
                  err_d = 1'b1;
               end else begin
                  w_d     = cfg_width;
                  h_d     = cfg_height;
                  x_d     = '0;
                  y_d     = '0;
                  state_d = ST_WAIT_SOF;
               end
            end
         end
         ST_WAIT_SOF, ST_RUN: begin
            if (s_fire && ((state_q == ST_RUN) || bus.s_sof)) begin
               if (state_q == ST_RUN && bus.s_sof) err_d = 1'b1;
               mv_d   = 1'b1;
               md_d   = pix888;
               msof_d = bus.s_sof;
               meol_d = last_x;
               meof_d = last_x && last_y;
               if (last_x && last_y) begin
                  x_d     = '0;
                  y_d     = '0;
                  state_d = ST_DRAIN;
               end else if (last_x) begin
                  x_d     = '0;
                  y_d     = py + DIM_W'(1);
                  state_d = ST_RUN;
               end else begin
                  x_d     = px + DIM_W'(1);
                  y_d     = py;
                  state_d = ST_RUN;
               end
            end
         end
         ST_DRAIN: begin
            // Only the EOF beat can be in the output register here.
            if (m_fire) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         w_q     <= '0;
         h_q     <= '0;
         mv_q    <= 1'b0;
         md_q    <= '0;
         msof_q  <= 1'b0;
         meol_q  <= 1'b0;
         meof_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         w_q     <= w_d;
         h_q     <= h_d;
         mv_q    <= mv_d;
         md_q    <= md_d;
         msof_q  <= msof_d;
         meol_q  <= meol_d;
         meof_q  <= meof_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign bus.s_ready = s_ready_int;
   assign bus.m_valid = mv_q;
   assign bus.m_data  = md_q;
   assign bus.m_sof   = msof_q;
   assign bus.m_eol   = meol_q;
   assign bus.m_eof   = meof_q;

endmodule

// File: tb/tb_rgb565_frame_ctrl.sv
// Scoreboard bench for rgb565_frame_ctrl: directed frames with hand-computed RGB888 beats.
module tb_rgb565_frame_ctrl;
   import video_pkg::*;

   localparam int DIM_W = 12;

   typedef struct packed {
      logic [23:0] data;
      logic        sof;
      logic        eol;
      logic        eof;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_start = 1'b0;
   logic [DIM_W-1:0] cfg_width = '0;
   logic [DIM_W-1:0] cfg_height = '0;
   logic             busy, done, err;

   rgb565_frame_ctrl_if bus ();

   rgb565_frame_ctrl #(.DIM_W(DIM_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    passes = 0;
   beat_t exp_q[$];
   int    cyc = 0;
   int    done_exp_cyc = -10;
   int    done_cnt = 0;
   int    err_cnt = 0;
   bit    rand_ready = 1'b0;
   bit    ready_fix = 1'b1;
   bit    prev_stall = 1'b0;
   beat_t prev_beat = '0;

   logic [15:0] pix [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                            16'h0000, 16'h8410, 16'h0821, 16'hAAAA};
   logic [23:0] rgb [8] = '{24'hF80000, 24'h00FC00, 24'h0000F8, 24'hF8FCF8,
                            24'h000000, 24'h808080, 24'h080408, 24'hA85450};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0h, required %0h", name, act, expv);
   endtask

   always @(posedge clk) cyc++;

   // Single driver of m_ready: fixed level or 50% random.
   always @(posedge clk) begin
      #1;
      if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
      else            bus.m_ready = ready_fix;
   end

   // Monitor: pops the scoreboard on every output handshake and checks stall stability and done timing.
   always @(negedge clk) begin
      beat_t cur;
      beat_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         cur = {bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof};
         if (prev_stall) begin
            chk("stall_valid", 32'(bus.m_valid), 32'd1);
            chk("stall_stable", 32'(cur), 32'(prev_beat));
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL extra_beat: got beat %h, required no beat", cur);
            end else begin
               e = exp_q.pop_front();
               chk("beat", 32'(cur), 32'(e));
               if (bus.m_eof) done_exp_cyc = cyc + 1;
            end
         end
         if (cyc == done_exp_cyc) chk("done_timing", 32'(done), 32'd1);
         else if (done) begin
            checks++;
            $display("FAIL done_spurious: got done=1 at cycle %0d, required 0", cyc);
         end
         if (done) done_cnt++;
         if (err)  err_cnt++;
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_beat  = cur;
      end
   end

   task automatic push(input logic [23:0] d, input logic sof, input logic eol, input logic eof);
      beat_t b;
      b = {d, sof, eol, eof};
      exp_q.push_back(b);
   endtask

   task automatic arm(input int w, input int h);
      cfg_width  = DIM_W'(w);
      cfg_height = DIM_W'(h);
      cfg_start  = 1'b1;
      @(posedge clk); #1;
      cfg_start  = 1'b0;
   endtask

   task automatic send(input logic [15:0] d, input logic sof);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_sof   = sof;
      @(negedge clk);
      while (!bus.s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!bus.s_ready) begin
         checks++;
         $display("FAIL send_timeout: s_ready=0 after %0d cycles, required 1", n);
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
   endtask

   // Full 4x2 frame from the pixel table, SOF on beat 0.
   task automatic frame_4x2();
      for (int i = 0; i < 8; i++) begin
         push(rgb[i], i == 0, (i % 4) == 3, i == 7);
         send(pix[i], i == 0);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy || exp_q.size() != 0) begin
         checks++;
         $display("FAIL %s_timeout: busy=%0d pending=%0d, required 0 0", name, busy, exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0, e0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_sof   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_done",    32'(done), 32'd0);
      chk("rst_err",     32'(err), 32'd0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_data",  32'(bus.m_data), 32'd0);
      chk("rst_marks",   32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic 4x2 frame; a zero-size cfg_start mid-frame must be ignored silently.
      d0 = done_cnt; e0 = err_cnt;
      arm(4, 2);
      chk("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         push(rgb[i], i == 0, (i % 4) == 3, i == 7);
         send(pix[i], i == 0);
         if (i == 2) arm(0, 0);
      end
      wait_idle("t1");
      chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("t1_err_cnt",  32'(err_cnt - e0), 32'd0);

      // Non-SOF beats before SOF are dropped.
      d0 = done_cnt;
      arm(4, 2);
      send(16'h1234, 1'b0);
      send(16'h5678, 1'b0);
      send(16'h9ABC, 1'b0);
      frame_4x2();
      wait_idle("t3");
      chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Random backpressure over two frames.
      d0 = done_cnt;
      rand_ready = 1'b1;
      arm(4, 2);
      frame_4x2();
      wait_idle("t4a");
      arm(4, 2);
      frame_4x2();
      wait_idle("t4b");
      rand_ready = 1'b0;
      @(posedge clk); #1;
      chk("t4_done_cnt", 32'(done_cnt - d0), 32'd2);

      // Early SOF on pixel 5 restarts the frame.
      d0 = done_cnt; e0 = err_cnt;
      arm(4, 2);
      for (int i = 0; i < 4; i++) begin
         push(rgb[i], i == 0, i == 3, 1'b0);
         send(pix[i], i == 0);
      end
      push(rgb[7], 1'b1, 1'b0, 1'b0);
      send(pix[7], 1'b1);
      chk("t5_err_pulse", 32'(err), 32'd1);
      for (int i = 1; i < 8; i++) begin
         push(rgb[i], 1'b0, (i % 4) == 3, i == 7);
         send(pix[i], 1'b0);
      end
      wait_idle("t5");
      chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("t5_err_cnt",  32'(err_cnt - e0), 32'd1);

      // Zero-size configurations.
      arm(0, 2);
      chk("t6_err_w0",  32'(err), 32'd1);
      chk("t6_busy_w0", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("t6_err_clear", 32'(err), 32'd0);
      arm(3, 0);
      chk("t6_err_h0",  32'(err), 32'd1);
      chk("t6_busy_h0", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset mid-frame with a beat held in the output register.
      ready_fix = 1'b0;
      arm(4, 2);
      push(rgb[0], 1'b1, 1'b0, 1'b0);
      send(pix[0], 1'b1);
      chk("t7_held_valid", 32'(bus.m_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_busy",    32'(busy), 32'd0);
      chk("t7_rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("t7_rst_m_data",  32'(bus.m_data), 32'd0);
      chk("t7_rst_marks",   32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'd0);
      chk("t7_rst_s_ready", 32'(bus.s_ready), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_fix = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1x1 frame: one beat carries SOF, EOL and EOF.
      d0 = done_cnt;
      arm(1, 1);
      push(rgb[7], 1'b1, 1'b1, 1'b1);
      send(pix[7], 1'b1);
      wait_idle("t8");
      chk("t8_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
